// File: rtl/dac_interface_serial.sv
// rtl/dac_interface_serial.sv - serial SYNC/SCLK/DIN/LDAC write controller for the bias DAC
// Optional LDAC pulse after each frame: define DAC_LDAC_PULSE_EN.
module dac_interface_serial #(
  parameter int NBIT    = 24,
  parameter int CLK_DIV = 2,
  parameter int T_QUIET = 3,
  parameter int T_LDAC  = 2
) (
  input  logic            clk0,
  input  logic            rst,
  input  logic            en,
  input  logic [NBIT-1:0] din,
  output logic            rdy,
  output logic            SYNC,
  output logic            SCLK,
  output logic            DIN,
  output logic            LDAC,
  output logic [3:0]      state
);

  localparam int M1   = (NBIT > 2 * CLK_DIV) ? NBIT : 2 * CLK_DIV;
  localparam int M2   = (M1 > T_QUIET) ? M1 : T_QUIET;
  localparam int MAXV = (M2 > T_LDAC) ? M2 : T_LDAC;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [3:0] {
    s_idle  = 4'd0,
    s_load  = 4'd1,
    s_shift = 4'd2,
    s_quiet = 4'd3,
    s_ldac  = 4'd4
  } state_t;

  state_t          state_q, state_d;
  logic [NBIT-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync_q, sync_d;
  logic            sclk_q, sclk_d;
  logic            dout_q, dout_d;
  logic            ldac_q, ldac_d;
  logic            rdy_q, rdy_d;

  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state_q <= s_idle;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= 1'b0;
      ldac_q  <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      ldac_q  <= ldac_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    ldac_d  = ldac_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      s_idle: begin
        rdy_d = 1'b1;
        if (en) begin
          shreg_d = din;
          rdy_d   = 1'b0;
          state_d = s_load;
        end
      end
      s_load: begin
        sync_d  = 1'b0;
        dout_d  = shreg_q[NBIT-1];
        bit_d   = '0;
        div_d   = '0;
        state_d = s_shift;
      end
      s_shift: begin
        // div_q counts clk0 edges within one SCLK period; DIN only moves on the rising edge
        div_d = div_q + CW'(1);
        if (div_q == CW'(CLK_DIV - 1)) sclk_d = 1'b0;
        if (div_q == CW'(2 * CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = 1'b1;
          if (bit_q == CW'(NBIT - 1)) begin
            sync_d  = 1'b1;
            dout_d  = 1'b0;
            cnt_d   = '0;
            state_d = s_quiet;
          end else begin
            shreg_d = shreg_q << 1;
            dout_d  = shreg_q[NBIT-2];
            bit_d   = bit_q + CW'(1);
          end
        end
      end
      s_quiet: begin
        if (cnt_q == CW'(T_QUIET - 1)) begin
          cnt_d = '0;
`ifdef DAC_LDAC_PULSE_EN
          ldac_d  = 1'b0;
          state_d = s_ldac;
`else
          rdy_d   = 1'b1;
          state_d = s_idle;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      s_ldac: begin
        if (cnt_q == CW'(T_LDAC - 1)) begin
          cnt_d   = '0;
          ldac_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = s_idle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = s_idle;
    endcase
`ifndef DAC_LDAC_PULSE_EN
    // transparent update: LDAC tied low whenever out of reset
    ldac_d = 1'b0;
`endif
  end

  assign rdy   = rdy_q;
  assign SYNC  = sync_q;
  assign SCLK  = sclk_q;
  assign DIN   = dout_q;
  assign LDAC  = ldac_q;
  assign state = state_q;

endmodule

// File: tb/tb_dac_interface_serial.sv
// tb/tb_dac_interface_serial.sv - randomized frame checks for dac_interface_serial
module tb_dac_interface_serial;

  localparam int TQ = 3;
`ifdef DAC_LDAC_PULSE_EN
  localparam int TL = 2;
  localparam bit LDAC_ON = 1'b1;
`else
  localparam int TL = 0;
  localparam bit LDAC_ON = 1'b0;
`endif

  logic clk0 = 1'b0;
  logic rst = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0;
  logic [23:0] din1 = '0;
  logic [15:0] din2 = '0;
  logic rdy1, sync1, sclk1, dout1, ldac1;
  logic rdy2, sync2, sclk2, dout2, ldac2;
  logic [3:0] state1, state2;
  logic sel = 1'b0;
  int cyc = 0;
  int n_cmp = 0, n_err = 0;

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  dac_interface_serial u_dut1 (
    .clk0(clk0), .rst(rst), .en(en1), .din(din1), .rdy(rdy1),
    .SYNC(sync1), .SCLK(sclk1), .DIN(dout1), .LDAC(ldac1), .state(state1)
  );

  dac_interface_serial #(.NBIT(16), .CLK_DIV(1)) u_dut2 (
    .clk0(clk0), .rst(rst), .en(en2), .din(din2), .rdy(rdy2),
    .SYNC(sync2), .SCLK(sclk2), .DIN(dout2), .LDAC(ldac2), .state(state2)
  );

  wire       m_sync  = sel ? sync2  : sync1;
  wire       m_sclk  = sel ? sclk2  : sclk1;
  wire       m_din   = sel ? dout2  : dout1;
  wire       m_rdy   = sel ? rdy2   : rdy1;
  wire       m_ldac  = sel ? ldac2  : ldac1;
  wire [3:0] m_state = sel ? state2 : state1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observes one frame from the sample after E0 until rdy is seen, then scores it.
  task automatic watch_frame(input string tag, input int nb, input int cd,
                             input logic [31:0] w, input int e0, output int rdy_at);
    int falls = 0, sync_low = 0, sync_rise = -1, ldac_start = -1, ldac_len = 0;
    int ldac_bad = 0, n = 0;
    logic [31:0] got = '0;
    logic prev_sclk = 1'b1, prev_sync = 1'b1;
    logic [3:0] st_at_rdy = 4'hf;
    rdy_at = -1;
    for (int i = 0; i < 400 && rdy_at < 0; i++) begin
      @(negedge clk0);
      n++;
      if (!m_sync) sync_low++;
      if (prev_sclk && !m_sclk && !m_sync) begin
        falls++;
        got = {got[30:0], m_din};
      end
      if (!prev_sync && m_sync && sync_rise < 0) sync_rise = cyc;
      if (!m_ldac) begin
        if (ldac_start < 0) ldac_start = cyc;
        ldac_len++;
        if (!m_sync) ldac_bad++;
      end
      if (m_rdy) begin
        rdy_at = cyc;
        st_at_rdy = m_state;
      end
      prev_sclk = m_sclk;
      prev_sync = m_sync;
    end
    chk({tag, " falls"}, falls, nb);
    chk({tag, " word"}, got, w);
    chk({tag, " sync_low"}, sync_low, 2 * cd * nb);
    chk({tag, " sync_rise"}, sync_rise - e0, 1 + 2 * cd * nb);
    chk({tag, " rdy_at"}, rdy_at - e0, 1 + 2 * cd * nb + TQ + TL);
    chk({tag, " idle_state"}, st_at_rdy, 0);
    if (LDAC_ON) begin
      chk({tag, " ldac_start"}, ldac_start - sync_rise, TQ);
      chk({tag, " ldac_len"}, ldac_len, TL);
      chk({tag, " ldac_in_frame"}, ldac_bad, 0);
    end else begin
      chk({tag, " ldac_tied_low"}, ldac_len, n);
    end
  endtask

  task automatic start1(input logic [23:0] w, output int e0);
    @(negedge clk0);
    din1 = w;
    en1  = 1'b1;
    @(posedge clk0);
    #1;
    en1 = 1'b0;
    e0  = cyc;
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    int lows = 0;
    repeat (ncyc) begin
      @(negedge clk0);
      if (!m_sync) lows++;
    end
    chk({tag, " no_extra_frame"}, lows, 0);
  endtask

  initial begin
    int e0, r;
    logic [23:0] w;

    repeat (3) @(negedge clk0);
    chk("rst sync", sync1, 1);
    chk("rst sclk", sclk1, 1);
    chk("rst din", dout1, 0);
    chk("rst ldac", ldac1, 1);
    chk("rst rdy", rdy1, 0);
    chk("rst state", state1, 0);
    rst = 1'b1;
    @(negedge clk0);
    chk("rel rdy", rdy1, 1);
    chk("rel sync", sync1, 1);
    chk("rel sclk", sclk1, 1);
    chk("rel ldac", ldac1, LDAC_ON ? 1 : 0);
    chk("rel state", state1, 0);

    // fixed word; din corrupted and en re-pulsed mid-frame
    start1(24'hA5C3F0, e0);
    fork
      watch_frame("a5c3f0", 24, 2, 32'hA5C3F0, e0, r);
      begin
        do @(negedge clk0); while (cyc < e0 + 5);
        din1 = 24'h000000;
        do @(negedge clk0); while (cyc < e0 + 30);
        en1 = 1'b1;
        @(negedge clk0);
        en1 = 1'b0;
      end
    join
    idle_check("a5c3f0", 10);

    for (int k = 0; k < 4; k++) begin
      w = 24'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk0);
      start1(w, e0);
      watch_frame($sformatf("rnd%0d", k), 24, 2, {8'h0, w}, e0, r);
    end

    // asynchronous reset part-way through a frame
    start1(24'($urandom), e0);
    do @(negedge clk0); while (cyc < e0 + 40);
    #2 rst = 1'b0;
    #1;
    chk("arst sync", sync1, 1);
    chk("arst sclk", sclk1, 1);
    chk("arst ldac", ldac1, 1);
    chk("arst rdy", rdy1, 0);
    chk("arst state", state1, 0);
    @(negedge clk0);
    rst = 1'b1;
    @(negedge clk0);
    chk("arst rel rdy", rdy1, 1);
    w = 24'($urandom);
    start1(w, e0);
    watch_frame("post_rst", 24, 2, {8'h0, w}, e0, r);

    // narrow instance, en held high: back-to-back frames
    sel = 1'b1;
    @(negedge clk0);
    din2 = 16'h8001;
    en2  = 1'b1;
    @(posedge clk0);
    #1;
    e0 = cyc;
    watch_frame("b2b0", 16, 1, 32'h8001, e0, r);
    fork
      watch_frame("b2b1", 16, 1, 32'h8001, r + 1, r);
      begin
        @(posedge clk0);
        #1 en2 = 1'b0;
      end
    join
    idle_check("b2b", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
